// File: rtl/edge_pkg.sv
// Shared definitions for the edge detector: scan sequencer state encoding,
// default image dimensions and coordinate/counter widths.
package edge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAW  = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } edge_scan_state_t;

  localparam int DEF_IMG_W = 16;
  localparam int DEF_IMG_H = 16;
  localparam int DEF_XW    = 10;
  localparam int DEF_YW    = 10;
  localparam int DEF_CW    = 20;

endpackage

// File: rtl/edge_xy_counter.sv
// Raster-order x/y pixel counter. clear returns to (0,0); step advances one
// pixel, wrapping x at the end of a row and moving down one row.
// is_border / is_last are decoded from the registered coordinates.
module edge_xy_counter
  import edge_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int XW    = DEF_XW,
  parameter int YW    = DEF_YW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          is_border,
  output logic          is_last
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // Coordinate registers: clear has priority over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign is_border = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
  assign is_last   = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/edge_scan_ctrl.sv
// Frame-level sequencer for the edge detector pixel core. Scans the image in
// raster order, runs the core on interior pixels, writes every pixel's edge
// bit to the drawing engine, and counts the edge pixels of the frame.
//
// Handshakes: every *_req is a level held from state entry until the clock
// edge on which its *_ack is sampled high; the request is low in the next
// cycle. Coordinates and data are stable while a request is high. An ack is
// only looked at while its own request is high. The host req/ack pair is
// 4-phase: ack stays high until req has been seen low.
module edge_scan_ctrl
  import edge_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int XW    = DEF_XW,
  parameter int YW    = DEF_YW,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic             ack,
  output logic             busy,
  output logic             pix_req,
  input  logic             pix_ack,
  output logic [XW-1:0]    pix_x,
  output logic [YW-1:0]    pix_y,
  input  logic             edge_in,
  output logic             de_req,
  input  logic             de_ack,
  output logic [XW-1:0]    de_x,
  output logic [YW-1:0]    de_y,
  output logic             de_data,
  output logic [CW-1:0]    edge_count,
  output edge_scan_state_t state_dbg
);

  edge_scan_state_t state;
  logic             result;
  logic             cnt_clear;
  logic             cnt_step;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             is_border;
  logic             is_last;

  assign cnt_clear = (state == ST_IDLE) && req;
  assign cnt_step  = (state == ST_STEP) && !is_last;

  edge_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_xy (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .step      (cnt_step),
    .x         (x),
    .y         (y),
    .is_border (is_border),
    .is_last   (is_last)
  );

  // Scan FSM with the latched core result and the frame edge counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      result     <= 1'b0;
      edge_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            edge_count <= '0;
            result     <= 1'b0;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Border pixels bypass the core and are always drawn as 0.
          if (is_border) begin
            result <= 1'b0;
            state  <= ST_DRAW;
          end else if (pix_ack) begin
            result <= edge_in;
            state  <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (de_ack) begin
            edge_count <= edge_count + CW'(result);
            state      <= ST_STEP;
          end
        end
        ST_STEP: begin
          state <= is_last ? ST_DONE : ST_FETCH;
        end
        ST_DONE: begin
          if (!req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state and coordinates only.
  assign busy      = (state == ST_FETCH) || (state == ST_DRAW) || (state == ST_STEP);
  assign ack       = (state == ST_DONE);
  assign pix_req   = (state == ST_FETCH) && !is_border;
  assign de_req    = (state == ST_DRAW);
  assign de_data   = (state == ST_DRAW) && result;
  assign pix_x     = x;
  assign pix_y     = y;
  assign de_x      = x;
  assign de_y      = y;
  assign state_dbg = state;

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Directed bench for edge_scan_ctrl on a 4x4 image.
module tb_edge_scan_ctrl;
  import edge_pkg::*;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int XW    = 10;
  localparam int YW    = 10;
  localparam int CW    = 20;
  localparam int WW    = XW + YW + 1;

  logic             clk;
  logic             rst_n;
  logic             req;
  logic             ack;
  logic             busy;
  logic             pix_req;
  logic             pix_ack;
  logic [XW-1:0]    pix_x;
  logic [YW-1:0]    pix_y;
  logic             edge_in;
  logic             de_req;
  logic             de_ack;
  logic [XW-1:0]    de_x;
  logic [YW-1:0]    de_y;
  logic             de_data;
  logic [CW-1:0]    edge_count;
  edge_scan_state_t state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: expected writes {x, y, data}, observed writes, core requests.
  logic [WW-1:0]      exp_q[$];
  logic [WW-1:0]      got_q[$];
  logic [XW+YW-1:0]   pix_q[$];
  int                 fr_cycles;
  int                 fr_stab_err;
  int                 fr_first_cnt;
  bit                 fr_timeout;

  edge_scan_ctrl #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .XW (XW), .YW (YW), .CW (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .ack        (ack),
    .busy       (busy),
    .pix_req    (pix_req),
    .pix_ack    (pix_ack),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .edge_in    (edge_in),
    .de_req     (de_req),
    .de_ack     (de_ack),
    .de_x       (de_x),
    .de_y       (de_y),
    .de_data    (de_data),
    .edge_count (edge_count),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected write sequence: border 0, interior 1 (or alternating 1,0,...).
  function automatic void build_exp(input bit alt);
    int  k;
    bit  border;
    logic d;
    k = 0;
    exp_q.delete();
    for (int yy = 0; yy < IMG_H; yy++) begin
      for (int xx = 0; xx < IMG_W; xx++) begin
        border = (xx == 0) || (xx == IMG_W - 1) || (yy == 0) || (yy == IMG_H - 1);
        if (border) d = 1'b0;
        else begin
          d = alt ? ((k % 2) == 0) : 1'b1;
          k++;
        end
        exp_q.push_back({XW'(xx), YW'(yy), d});
      end
    end
  endfunction

  // Driver: raises req and plays core + drawing engine until ack is seen.
  // de_delay=0 ties de_ack high; otherwise de_ack rises in the de_delay-th
  // cycle of each write request.
  task automatic run_frame(input int de_delay, input bit alt);
    int            wait_cnt;
    bit            held_valid;
    logic [WW-1:0] held;
    got_q.delete();
    pix_q.delete();
    fr_cycles    = 0;
    fr_stab_err  = 0;
    fr_first_cnt = -1;
    fr_timeout   = 1'b0;
    wait_cnt     = 0;
    held_valid   = 1'b0;
    held         = '0;
    @(negedge clk);
    req     = 1'b1;
    pix_ack = 1'b1;
    edge_in = 1'b1;
    de_ack  = (de_delay == 0);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      fr_cycles++;
      @(negedge clk);
      if (fr_cycles == 1) fr_first_cnt = int'(edge_count);
      if (ack) break;
      if (pix_req) begin
        edge_in = alt ? ((pix_q.size() % 2) == 0) : 1'b1;
        pix_q.push_back({pix_x, pix_y});
      end
      if (de_req) begin
        if (held_valid && ({de_x, de_y, de_data} !== held)) fr_stab_err++;
        held       = {de_x, de_y, de_data};
        held_valid = 1'b1;
        if (de_delay == 0) de_ack = 1'b1;
        else begin
          wait_cnt++;
          de_ack = (wait_cnt >= de_delay);
        end
        if (de_ack) begin
          got_q.push_back(held);
          held_valid = 1'b0;
          wait_cnt   = 0;
        end
      end else begin
        held_valid = 1'b0;
        wait_cnt   = 0;
        if (de_delay != 0) de_ack = 1'b0;
      end
    end
    if (!ack) fr_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; pix_ack = 1'b0; de_ack = 1'b0; edge_in = 1'b0;
    #12;
    n_checks++; if (state_dbg !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    n_checks++; if (ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (pix_req !== 1'b0) begin n_errors++; $display("FAIL reset_pix_req: got %b expected 0", pix_req); end
    n_checks++; if (de_req !== 1'b0) begin n_errors++; $display("FAIL reset_de_req: got %b expected 0", de_req); end
    n_checks++; if (de_data !== 1'b0) begin n_errors++; $display("FAIL reset_de_data: got %b expected 0", de_data); end
    n_checks++; if ({pix_x, pix_y} !== '0) begin n_errors++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", pix_x, pix_y); end
    n_checks++; if (edge_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", edge_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    build_exp(1'b0);
    run_frame(0, 1'b0);
    n_checks++; if (fr_timeout) begin n_errors++; $display("FAIL basic_timeout: got no ack expected ack"); end
    n_checks++; if (fr_cycles !== 49) begin n_errors++; $display("FAIL basic_latency: got %0d expected 49", fr_cycles); end
    n_checks++; if (fr_first_cnt !== 0) begin n_errors++; $display("FAIL basic_count_clear: got %0d expected 0", fr_first_cnt); end
    n_checks++; if (got_q.size() !== 16) begin n_errors++; $display("FAIL basic_writes: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL basic_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++; if (pix_q.size() !== 4) begin n_errors++; $display("FAIL basic_pix_reqs: got %0d expected 4", pix_q.size()); end
    if (pix_q.size() == 4) begin
      n_checks++; if (pix_q[0] !== {XW'(1), YW'(1)}) begin n_errors++; $display("FAIL basic_pix0: got %h expected (1,1)", pix_q[0]); end
      n_checks++; if (pix_q[1] !== {XW'(2), YW'(1)}) begin n_errors++; $display("FAIL basic_pix1: got %h expected (2,1)", pix_q[1]); end
      n_checks++; if (pix_q[2] !== {XW'(1), YW'(2)}) begin n_errors++; $display("FAIL basic_pix2: got %h expected (1,2)", pix_q[2]); end
      n_checks++; if (pix_q[3] !== {XW'(2), YW'(2)}) begin n_errors++; $display("FAIL basic_pix3: got %h expected (2,2)", pix_q[3]); end
    end
    n_checks++; if (edge_count !== CW'(4)) begin n_errors++; $display("FAIL basic_count: got %0d expected 4", edge_count); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
  endtask

  task automatic test_req_held();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL held_ack[%0d]: got %b expected 1", i, ack); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL held_busy[%0d]: got %b expected 0", i, busy); end
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (state_dbg !== ST_IDLE) begin n_errors++; $display("FAIL release_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    n_checks++; if (ack !== 1'b0) begin n_errors++; $display("FAIL release_ack: got %b expected 0", ack); end
    n_checks++; if (edge_count !== CW'(4)) begin n_errors++; $display("FAIL release_count_hold: got %0d expected 4", edge_count); end
  endtask

  task automatic test_de_delay();
    build_exp(1'b0);
    run_frame(5, 1'b0);
    n_checks++; if (fr_timeout) begin n_errors++; $display("FAIL delay_timeout: got no ack expected ack"); end
    n_checks++; if (fr_cycles !== 49 + 16 * 4) begin n_errors++; $display("FAIL delay_latency: got %0d expected %0d", fr_cycles, 49 + 16 * 4); end
    n_checks++; if (fr_stab_err !== 0) begin n_errors++; $display("FAIL delay_stability: got %0d changes expected 0", fr_stab_err); end
    n_checks++; if (fr_first_cnt !== 0) begin n_errors++; $display("FAIL delay_count_clear: got %0d expected 0", fr_first_cnt); end
    n_checks++; if (got_q.size() !== 16) begin n_errors++; $display("FAIL delay_writes: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL delay_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++; if (edge_count !== CW'(4)) begin n_errors++; $display("FAIL delay_count: got %0d expected 4", edge_count); end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_alternating();
    build_exp(1'b1);
    run_frame(0, 1'b1);
    n_checks++; if (fr_timeout) begin n_errors++; $display("FAIL alt_timeout: got no ack expected ack"); end
    n_checks++; if (fr_first_cnt !== 0) begin n_errors++; $display("FAIL alt_count_clear: got %0d expected 0", fr_first_cnt); end
    n_checks++; if (got_q.size() !== 16) begin n_errors++; $display("FAIL alt_writes: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL alt_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++; if (edge_count !== CW'(2)) begin n_errors++; $display("FAIL alt_count: got %0d expected 2", edge_count); end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_ignored_acks();
    bit found;
    req = 1'b0; pix_ack = 1'b1; de_ack = 1'b1; edge_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (state_dbg !== ST_IDLE) begin n_errors++; $display("FAIL idle_ack_state[%0d]: got %0d expected %0d", i, state_dbg, ST_IDLE); end
      n_checks++; if (edge_count !== CW'(2)) begin n_errors++; $display("FAIL idle_ack_count[%0d]: got %0d expected 2", i, edge_count); end
    end
    pix_ack = 1'b0; de_ack = 1'b0; req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (state_dbg !== ST_DRAW) begin n_errors++; $display("FAIL draw_entry: got %0d expected %0d", state_dbg, ST_DRAW); end
    pix_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (state_dbg !== ST_DRAW || de_req !== 1'b1) begin n_errors++; $display("FAIL draw_pix_ack[%0d]: got state %0d de_req %b expected state %0d de_req 1", i, state_dbg, de_req, ST_DRAW); end
      n_checks++; if (edge_count !== '0 || pix_x !== '0) begin n_errors++; $display("FAIL draw_hold[%0d]: got count %0d x %0d expected 0 0", i, edge_count, pix_x); end
    end
    // Walk the border with de_ack only; core never answers.
    pix_ack = 1'b0; de_ack = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pix_req) found = 1'b1;
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL pix_req_seen: got none expected pix_req at (1,1)"); end
    n_checks++; if (pix_x !== XW'(1) || pix_y !== YW'(1)) begin n_errors++; $display("FAIL pix_req_xy: got (%0d,%0d) expected (1,1)", pix_x, pix_y); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (pix_req !== 1'b1) begin n_errors++; $display("FAIL pix_req_hold[%0d]: got %b expected 1", i, pix_req); end
    end
  endtask

  task automatic test_reset_mid();
    // Entered at a negedge with pix_req high at (1,1) and req still high.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pix_req !== 1'b0 || de_req !== 1'b0) begin n_errors++; $display("FAIL midrst_reqs: got pix_req %b de_req %b expected 0 0", pix_req, de_req); end
    n_checks++; if (busy !== 1'b0 || ack !== 1'b0) begin n_errors++; $display("FAIL midrst_busy_ack: got %b %b expected 0 0", busy, ack); end
    n_checks++; if (pix_x !== '0 || pix_y !== '0 || edge_count !== '0) begin n_errors++; $display("FAIL midrst_regs: got (%0d,%0d) count %0d expected (0,0) 0", pix_x, pix_y, edge_count); end
    @(negedge clk);
    rst_n = 1'b1;
    pix_ack = 1'b0; de_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (state_dbg !== ST_FETCH || busy !== 1'b1) begin n_errors++; $display("FAIL midrst_restart: got state %0d busy %b expected %0d 1", state_dbg, busy, ST_FETCH); end
    n_checks++; if (pix_x !== '0 || pix_y !== '0) begin n_errors++; $display("FAIL midrst_restart_xy: got (%0d,%0d) expected (0,0)", pix_x, pix_y); end
    req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_req_held();
    test_de_delay();
    test_alternating();
    test_ignored_acks();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_scan_ctrl.md
# edge_scan_ctrl

Frame-level sequencer for the edge detector pixel core. On a host request it scans every pixel of an IMG_W × IMG_H image in raster order. For each pixel it starts the core with a req/ack handshake, captures the 1-bit edge result, and hands the result to the drawing engine with a second req/ack handshake. Border pixels are written as 0 without using the core. It sits between the host control interface and both the pixel core and the drawing engine.

## Interface
Parameters:
- IMG_W, 16: image width in pixels, ≥3
- IMG_H, 16: image height in pixels, ≥3
- XW, 10: width of x coordinate, 2^XW ≥ IMG_W
- YW, 10: width of y coordinate, 2^YW ≥ IMG_H
- CW, 20: width of edge counter, 2^CW > IMG_W*IMG_H

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  host frame request, level, 4-phase
- ack  out  1  frame complete, held until req falls
- busy  out  1  frame scan in progress
- pix_req  out  1  start core on (pix_x, pix_y)
- pix_ack  in  1  core result valid on edge_in
- pix_x  out  XW  current column
- pix_y  out  YW  current row
- edge_in  in  1  core result, sampled with pix_ack
- de_req  out  1  write request to drawing engine
- de_ack  in  1  drawing engine accepted write
- de_x  out  XW  write column (= pix_x)
- de_y  out  YW  write row (= pix_y)
- de_data  out  1  edge value to draw
- edge_count  out  CW  number of 1 results this frame

## Operation
- Moore FSM. States: IDLE, FETCH, DRAW, STEP, DONE. All outputs are decoded from registered state and counters only.
- IDLE: busy=0, ack=0. When req=1 at a clock edge: x=0, y=0, edge_count=0, go to FETCH.
- FETCH, border pixel (x==0, x==IMG_W-1, y==0 or y==IMG_H-1): pix_req=0, result=0, go to DRAW next edge.
- FETCH, interior pixel: pix_req=1. On an edge with pix_ack=1: latch result=edge_in, go to DRAW. pix_ack is ignored whenever pix_req=0.
- DRAW: de_req=1, de_data=result. On an edge with de_ack=1: edge_count += result, go to STEP. de_ack is ignored outside DRAW.
- STEP: if x==IMG_W-1 and y==IMG_H-1, go to DONE. Otherwise x+1; when x==IMG_W-1, x wraps to 0 and y+1. Then go to FETCH.
- DONE: ack=1, busy=0. Go to IDLE on an edge with req=0. A frame is never restarted without req first falling.
- busy=1 in FETCH, DRAW and STEP.
- req falling mid-frame has no effect; the frame runs to completion.
- edge_count holds its value after DONE until the next frame start.
- Counter arithmetic is unsigned. Comparisons use IMG_W-1 and IMG_H-1 truncated to XW/YW bits.

## Timing
- Reset (async, rst_n=0): state=IDLE. ack, busy, pix_req, de_req, de_data are 0. pix_x, pix_y, edge_count are 0.
- Reset mid-frame: any outstanding pix_req or de_req drops immediately. No write is completed or retried. If req=1 at reset release, a fresh frame starts at the first edge.
- pix_req and de_req stay high from state entry until the edge on which the matching ack is sampled. They are low in the following cycle.
- Coordinates and de_data are stable for the whole time a request is high.
- Per pixel with both acks tied high: 3 cycles (FETCH, DRAW, STEP).
- Frame with acks tied high: ack rises 1 + 3·IMG_W·IMG_H cycles after the edge that samples req=1.
- Each cycle of ack delay stretches the owning state by exactly one cycle.

## Structure
- Shared package edge_pkg holds the state encoding (typedef edge_scan_state_t), the default image dimensions and the coordinate widths. The pixel core and the drawing interface reuse these.
- One sub-module: edge_xy_counter, the raster x/y counter. It has clear and step inputs, plus is_border and is_last flags. The FSM and counter live in edge_scan_ctrl.

## Test plan
- IMG_W=IMG_H=4, pix_ack=de_ack=1, edge_in=1, req pulse held → exactly 16 de_req writes in raster order (0,0)…(3,3); only 4 pix_req (interior (1,1),(2,1),(1,2),(2,2)); edge_count=4; ack rises 49 cycles after req is sampled.
- Same setup, de_ack delayed 5 cycles on every write → de_x/de_y/de_data are stable while waiting; frame length is 49+16·4 cycles.
- edge_in alternating 1,0 across the interior pixels → de_data for border pixels is 0, interior pixels follow edge_in, edge_count=2.
- req held high through DONE → ack stays 1, no second frame starts; req=0 → IDLE next edge; req=1 again → new frame with edge_count cleared.
- rst_n pulsed low while pix_req=1 at (1,1) → all outputs 0 asynchronously; after release with req=1, scan restarts at (0,0).
- pix_ack=1 asserted while in DRAW or IDLE → ignored, no state change, edge_count unchanged.
